// File: rtl/interp_16p_pkg.sv
// ----------------------------------------------------------------------------
// interp_16p_pkg
// Shared types and widths for the 16-point interpolator (interp_16p) and its
// sign-magnitude output converter (tc2sm_8).
// ----------------------------------------------------------------------------
package interp_16p_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam int SAMPLES = 16;   // samples emitted per accepted word
    localparam int SAT_MAX = 127;  // largest magnitude an output sample may carry

    localparam int IN_W  = 12;     // two's-complement 16-sample sum
    localparam int SUM_W = 13;     // sum sign-extended by one bit for rounding
    localparam int AVG_W = 9;      // average / pre-saturation sample width
    localparam int SM_W  = 8;      // sign-magnitude output width
    localparam int ACC_W = 13;     // interpolation accumulator (sample * 16)
    localparam int IDX_W = 4;      // sample index 0..15
    localparam int CTR_W = 8;      // half-period counter, DIV up to 255

endpackage

// File: rtl/tc2sm_8.sv
// ----------------------------------------------------------------------------
// tc2sm_8
// Combinational saturating converter: 9-bit two's complement in, 8-bit
// sign-magnitude out. Inputs are clamped to [-127, +127] so the negative-zero
// code 8'h80 is never produced.
//
// Ports
//   din   in   9  two's-complement sample
//   dout  out  8  sign-magnitude sample (bit 7 sign, bits 6:0 magnitude)
// ----------------------------------------------------------------------------
module tc2sm_8
    import interp_16p_pkg::*;
(
    input  logic signed [AVG_W-1:0] din,
    output logic        [SM_W-1:0]  dout
);

    localparam logic signed [AVG_W-1:0] POS_LIM = AVG_W'(SAT_MAX);
    localparam logic signed [AVG_W-1:0] NEG_LIM = -POS_LIM;

    function automatic logic signed [AVG_W-1:0] sat_sym(input logic signed [AVG_W-1:0] v);
        if (v > POS_LIM)      return POS_LIM;
        else if (v < NEG_LIM) return NEG_LIM;
        else                  return v;
    endfunction

    logic signed [AVG_W-1:0] sat_v;
    logic        [SM_W-2:0]  mag;

    always_comb begin
        sat_v = sat_sym(din);
        mag   = sat_v[AVG_W-1] ? (SM_W-1)'(-sat_v) : (SM_W-1)'(sat_v);
        dout  = {sat_v[AVG_W-1], mag};
    end

endmodule

// File: rtl/interp_16p.sv
// ----------------------------------------------------------------------------
// interp_16p
// Expands one 12-bit two's-complement 16-sample sum into 16 paced 8-bit
// sign-magnitude samples. Each sample is presented on data_out and marked by a
// rising edge of syn_out; syn_out runs at DIV clk cycles per half-period.
// A word arriving while a burst is running waits in a single-entry pending
// register and follows the current burst without a gap; a second such word
// overwrites the first and raises ovf for one cycle.
//
// Build option
//   LINEAR_INTERP_EN  defined: samples ramp linearly from the previous burst's
//                     average to the new one. Undefined: every sample of a
//                     burst equals the rounded average (hold mode).
//
// Parameters
//   DIV    clk cycles per syn_out half-period, 1..255
//   N_LOG  log2 of samples per word, fixed at 4
//
// Ports
//   clk       in   1   system clock, posedge
//   res       in   1   asynchronous active-high reset
//   data_in   in   12  two's-complement sum of 16 samples
//   syn_in    in   1   word strobe, accepted on its rising edge
//   data_out  out  8   sign-magnitude sample
//   syn_out   out  1   sample clock, data_out stable across its rising edge
//   busy      out  1   high while a burst is emitted
//   ovf       out  1   one-cycle pulse when a pending word is overwritten
// ----------------------------------------------------------------------------
module interp_16p
    import interp_16p_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int N_LOG = 4
) (
    input  logic            clk,
    input  logic            res,
    input  logic [IN_W-1:0] data_in,
    input  logic            syn_in,
    output logic [SM_W-1:0] data_out,
    output logic            syn_out,
    output logic            busy,
    output logic            ovf
);

    if (N_LOG != 4 || DIV < 1 || DIV > 255) begin : g_param_check
        $error("interp_16p: DIV must be 1..255 and N_LOG must be 4");
    end

    localparam logic signed [AVG_W-1:0] POS_LIM = AVG_W'(SAT_MAX);
    localparam logic signed [AVG_W-1:0] NEG_LIM = -POS_LIM;

    // (sum + 8) >>> 4 : divide by 16, rounding halves towards +inf
    function automatic logic signed [AVG_W-1:0] round_avg(input logic [IN_W-1:0] d);
        logic signed [SUM_W-1:0] s;
        s = $signed({d[IN_W-1], d}) + SUM_W'(8);
        return AVG_W'(s >>> 4);
    endfunction

    function automatic logic signed [AVG_W-1:0] sat_avg(input logic signed [AVG_W-1:0] a);
        if (a > POS_LIM)      return POS_LIM;
        else if (a < NEG_LIM) return NEG_LIM;
        else                  return a;
    endfunction

`ifdef LINEAR_INTERP_EN
    function automatic logic signed [AVG_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a + ACC_W'(8);
        return AVG_W'(s >>> 4);
    endfunction
`endif

    state_t                  state;
    logic                    syn_d;
    logic [CTR_W-1:0]        ctr;
    logic [IDX_W-1:0]        idx;
    logic [IN_W-1:0]         pend_data;
    logic                    pend_vld;

    logic                    edge_c;
    logic                    half_done;
    logic                    burst_end;
    logic                    start_idle;
    logic                    start_next;
    logic                    start;
    logic                    advance;
    logic [IN_W-1:0]         start_word;
    logic signed [AVG_W-1:0] avg_new;
    logic signed [AVG_W-1:0] sample_tc;
    logic [SM_W-1:0]         sample_sm;

    // ---- stage 0: edge detect, word selection, average ----
    always_comb begin
        edge_c     = syn_in & ~syn_d;
        half_done  = (ctr == CTR_W'(DIV - 1));
        burst_end  = (state == HIGH) && half_done && (idx == IDX_W'(SAMPLES - 1));
        start_idle = (state == IDLE) && edge_c;
        start_next = burst_end && (edge_c || pend_vld);
        start      = start_idle || start_next;
        advance    = (state == HIGH) && half_done && !burst_end;
        // A fresh edge on the burst-end cycle wins over the pending word.
        start_word = (burst_end && !edge_c) ? pend_data : data_in;
        avg_new    = sat_avg(round_avg(start_word));
    end

`ifdef LINEAR_INTERP_EN
    logic signed [AVG_W-1:0] prev;
    logic signed [AVG_W-1:0] diff;
    logic signed [AVG_W-1:0] diff_new;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sel;

    // acc holds sample*16; the first sample of a burst is already one step
    // past prev, so the sixteenth lands exactly on the new average.
    always_comb begin
        diff_new  = avg_new - prev;
        acc_sel   = start ? ((ACC_W'(prev) <<< 4) + ACC_W'(diff_new))
                          : (acc + ACC_W'(diff));
        sample_tc = round_acc(acc_sel);
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc  <= acc_sel;
            diff <= diff_new;
        end else if (advance) begin
            acc  <= acc_sel;
        end
    end
`else
    assign sample_tc = avg_new;
`endif

    tc2sm_8 u_tc2sm (
        .din  (sample_tc),
        .dout (sample_sm)
    );

    // ---- stage 1: pending word storage ----
    always_ff @(posedge clk) begin
        if ((state != IDLE) && edge_c && !burst_end)
            pend_data <= data_in;
    end

    // ---- stage 1: control FSM, pacing counters, registered outputs ----
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state    <= IDLE;
            syn_d    <= 1'b0;
            ctr      <= '0;
            idx      <= '0;
            pend_vld <= 1'b0;
            data_out <= '0;
            syn_out  <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
`ifdef LINEAR_INTERP_EN
            prev     <= '0;
`endif
        end else begin
            syn_d <= syn_in;
            ovf   <= 1'b0;

            if (burst_end) begin
                pend_vld <= 1'b0;
            end else if ((state != IDLE) && edge_c) begin
                pend_vld <= 1'b1;
                ovf      <= pend_vld;
            end

            if (start) begin
                data_out <= sample_sm;
`ifdef LINEAR_INTERP_EN
                prev     <= avg_new;
`endif
            end else if (advance) begin
`ifdef LINEAR_INTERP_EN
                data_out <= sample_sm;
`endif
            end

            case (state)
                IDLE: begin
                    if (start_idle) begin
                        state   <= LOW;
                        ctr     <= '0;
                        idx     <= '0;
                        syn_out <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                LOW: begin
                    if (half_done) begin
                        ctr     <= '0;
                        syn_out <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        ctr <= ctr + CTR_W'(1);
                    end
                end
                HIGH: begin
                    if (half_done) begin
                        ctr     <= '0;
                        syn_out <= 1'b0;
                        if (!burst_end) begin
                            idx   <= idx + IDX_W'(1);
                            state <= LOW;
                        end else if (start_next) begin
                            idx   <= '0;
                            state <= LOW;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        ctr <= ctr + CTR_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    syn_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interp_16p.sv
// ----------------------------------------------------------------------------
// tb_interp_16p
// Directed bench for interp_16p with DIV=2. Each burst is watched cycle by
// cycle on the falling clock edge; the sample captured at every syn_out rise
// is compared against hand-computed values (hold mode) or the ramp formula
// (LINEAR_INTERP_EN builds).
// ----------------------------------------------------------------------------
module tb_interp_16p;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        res;
    logic [11:0] data_in;
    logic        syn_in;
    logic [7:0]  data_out;
    logic        syn_out;
    logic        busy;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    int          prev_avg = 0;
    logic [7:0]  rise_val [0:63];
    int          rise_cnt;
    int          busy_cnt;
    int          ovf_cnt;

    interp_16p #(.DIV(DIV), .N_LOG(4)) dut (
        .clk      (clk),
        .res      (res),
        .data_in  (data_in),
        .syn_in   (syn_in),
        .data_out (data_out),
        .syn_out  (syn_out),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sm_of(input int v);
        if (v < 0) return 128 | (-v);
        return v;
    endfunction

    // Expected sample k of a burst whose average is avg (hand value hold_sm
    // in hold mode), given the previous burst's average.
    function automatic int exp_sample(input int prev, input int avg, input int hold_sm, input int k);
`ifdef LINEAR_INTERP_EN
        int acc;
        acc = prev * 16 + (k + 1) * (avg - prev);
        return sm_of((acc + 8) >>> 4);
`else
        return hold_sm + 0 * (prev + avg + k);
`endif
    endfunction

    // Starts a burst with word w, optionally injects edges at cycle ta / tb
    // after the accepting edge, and stops early at cycle tr (for reset).
    task automatic burst(input logic [11:0] w,
                         input int ta, input logic [11:0] wa,
                         input int tb, input logic [11:0] wb,
                         input int tr);
        logic last_syn;
        @(negedge clk);
        data_in  = w;
        syn_in   = 1'b1;
        rise_cnt = 0;
        busy_cnt = 0;
        ovf_cnt  = 0;
        last_syn = syn_out;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (ovf) ovf_cnt++;
            if (syn_out && !last_syn) begin
                if (rise_cnt < 64) rise_val[rise_cnt] = data_out;
                rise_cnt++;
            end
            last_syn = syn_out;
            syn_in = 1'b0;
            if (n == tr) break;
            if (n == ta) begin
                data_in = wa;
                syn_in  = 1'b1;
            end
            if (n == tb) begin
                data_in = wb;
                syn_in  = 1'b1;
            end
            if (!busy) break;
        end
    endtask

    task automatic single(input string tag, input logic [11:0] w, input int avg, input int hold_sm);
        int pv;
        pv = prev_avg;
        burst(w, -1, 12'd0, -1, 12'd0, -1);
        chk({tag, "_rises"}, rise_cnt, 16);
        chk({tag, "_busy_cycles"}, busy_cnt, 32 * DIV);
        chk({tag, "_ovf"}, ovf_cnt, 0);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s_s%0d", tag, k), rise_val[k], exp_sample(pv, avg, hold_sm, k));
        chk({tag, "_hold_last"}, data_out, exp_sample(pv, avg, hold_sm, 15));
        chk({tag, "_synout_idle"}, syn_out, 0);
        prev_avg = avg;
    endtask

`ifdef LINEAR_INTERP_EN
    task automatic chk_ramp160(input string tag);
        int ramp [0:15] = '{1, 1, 2, 3, 3, 4, 4, 5, 6, 6, 7, 8, 8, 9, 9, 10};
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s_ramp%0d", tag, k), rise_val[k], ramp[k]);
    endtask
`endif

    initial begin
        res     = 1'b1;
        syn_in  = 1'b0;
        data_in = 12'd0;
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_syn_out", syn_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        res = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        single("p160", 12'd160, 10, 8'h0A);
`ifdef LINEAR_INTERP_EN
        chk_ramp160("p160");
`endif
        single("n160", 12'hF60, -10, 8'h8A);
        single("max", 12'd2047, 127, 8'h7F);
        single("min", 12'h800, -127, 8'hFF);
        single("m8", 12'hFF8, 0, 8'h00);
        single("m9", 12'hFF7, -1, 8'h81);
        single("p8", 12'd8, 1, 8'h01);

        // Back-to-back: pending word at C+10 is overwritten at C+20.
        begin
            int pv;
            pv = prev_avg;
            burst(12'd32, 10, 12'd32, 20, 12'd48, -1);
            chk("ovl_rises", rise_cnt, 32);
            chk("ovl_busy_cycles", busy_cnt, 64 * DIV);
            chk("ovl_ovf", ovf_cnt, 1);
            for (int k = 0; k < 16; k++)
                chk($sformatf("ovl_a_s%0d", k), rise_val[k], exp_sample(pv, 2, 8'h02, k));
            for (int k = 0; k < 16; k++)
                chk($sformatf("ovl_b_s%0d", k), rise_val[16 + k], exp_sample(2, 3, 8'h03, k));
            prev_avg = 3;
        end

        // Reset mid-burst with a word pending.
        burst(12'd160, 10, 12'd32, -1, 12'd0, 20);
        chk("mid_busy_before_rst", busy, 1);
        res = 1'b1;
        @(negedge clk);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_syn_out", syn_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf, 0);
        res = 1'b0;
        prev_avg = 0;
        begin
            int busy_seen;
            busy_seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (busy) busy_seen++;
            end
            chk("post_rst_no_pending", busy_seen, 0);
        end

        single("again160", 12'd160, 10, 8'h0A);
`ifdef LINEAR_INTERP_EN
        chk_ramp160("again160");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
